bit_timer: RTL and testbench
============================

Name: bit_timer

Overview:
- Receive-side bit timing controller that sits directly downstream of the programmable counter.
- It steers its counter's clear and count_enable inputs and consumes the counter's rollover indication.
- On a start-edge pulse, it first waits half a bit period to reach mid-bit. It then emits one shift strobe per bit period, and a packet-done pulse after the configured number of bits.
- It feeds the receive shift register and the receive control FSM.

Parameters:
NUM_CNT_BITS, 4, width of clks_per_bit, bits_per_packet and bit_index.

Ports:
clk  input  1  system clock, all state updates on rising edge
n_rst  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse, start-bit edge detected; honoured only in IDLE
abort  input  1  synchronous cancel of the current packet
clks_per_bit  input  NUM_CNT_BITS  clock cycles per bit period (C)
bits_per_packet  input  NUM_CNT_BITS  strobes per packet, data plus stop bits (B)
shift_strobe  output  1  one-cycle pulse at the mid-point of each bit
packet_done  output  1  one-cycle pulse after the last strobe
busy  output  1  high in every state except IDLE
bit_index  output  NUM_CNT_BITS  strobes issued so far in the current packet

Behaviour:
- Reset (asynchronous, n_rst=0):
  - State is IDLE.
  - shift_strobe=0, packet_done=0, busy=0, bit_index=0.
  - Latched configuration and cycle counter are cleared.
- All outputs are registered; there is no combinational path from input to output.
- Configuration latch:
  - clks_per_bit and bits_per_packet are latched on the edge at which start is accepted.
  - Changes while busy are ignored.
  - C<2 is treated as 2; B=0 is treated as 1.
- H = C>>1, using the latched and clamped C.
- States: IDLE, HALF, BITS, DONE.
- Transitions:
  - IDLE -> HALF: start=1 at edge E0. The cycle counter is cleared.
  - HALF -> BITS: after H cycles in HALF. The cycle counter is cleared and restarted.
  - BITS, strobe generation: the cycle counter rolls over every C cycles. Each rollover:
    - shift_strobe is high for exactly one cycle;
    - bit_index increments in the same cycle it becomes visible.
  - BITS -> DONE: on the B-th strobe.
  - DONE -> IDLE: after one cycle. packet_done=1 and busy=1 during DONE; bit_index holds B during DONE.
  - IDLE: bit_index returns to 0.
- Timing, counted in cycles after E0:
  - strobe k (k=1..B) is visible in cycle H + k*C;
  - packet_done is visible in cycle H + B*C + 1;
  - busy is visible from cycle 1 through cycle H + B*C + 1.
- start while busy (including during DONE): ignored, no effect.
- abort:
  - At any edge, in any state, next state is IDLE.
  - No strobe and no packet_done are produced; bit_index=0; counter cleared.
  - abort has priority over start in the same cycle.
- n_rst asserted mid-packet: immediate return to reset values; no trailing pulses after release.
- Width rules:
  - Cycle counter and bit counter are NUM_CNT_BITS wide.
  - Maximum C and B are 2^NUM_CNT_BITS-1.
  - No internal arithmetic overflow is permitted; the half computation is a shift only.

Decomposition:
- Shared package bit_timer_pkg:
  - typedef enum for state_t {IDLE, HALF, BITS, DONE};
  - localparam MIN_CLKS_PER_BIT=2 and MIN_BITS_PER_PACKET=1.
- One sub-module: flex_counter (existing, NUM_CNT_BITS wide) as the cycle counter.
  - rollover_val is H in HALF and C in BITS.
  - clear is driven on phase change and on abort.
- The bit counter is local logic inside bit_timer.

Test Plan:
- Reset: assert n_rst=0 mid-BITS, with C=10 and B=9 after 3 strobes -> all outputs 0 immediately; release and hold idle 20 cycles -> no strobes.
- Nominal packet: C=10, B=9, start at E0 -> strobes in cycles 15,25,...,95, bit_index 1..9, packet_done in cycle 96, busy low in cycle 97.
- Odd and minimum period:
  - C=7, B=2 -> H=3; strobes in cycles 10 and 17; packet_done in cycle 18.
  - C=1, B=0 -> clamped to C=2, B=1; strobe in cycle 3; packet_done in cycle 4.
- Config change and start while busy: C=4, B=3; change inputs to C=15, B=15 and pulse start in cycle 6 -> strobes still in cycles 6,10,14; packet_done in cycle 15.
- Abort: C=8, B=5; abort in cycle 20 -> busy=0 next cycle, no further strobes, no packet_done. Abort and start together in IDLE -> stays IDLE.
- Back-to-back: start in the cycle after packet_done drops -> second packet timing identical to the first, and bit_index restarts at 1.

Source files
------------

// File: rtl/bit_timer_pkg.sv
// Purpose : shared types and limits for the receive bit timer.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package bit_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HALF = 2'd1,
    BITS = 2'd2,
    DONE = 2'd3
  } state_t;

  // Smallest period that still has a non-zero half period, and smallest packet.
  localparam int MIN_CLKS_PER_BIT    = 2;
  localparam int MIN_BITS_PER_PACKET = 1;

endpackage

// File: rtl/flex_counter.sv
// Purpose : wrapping cycle counter, counts 1..rollover_val then restarts at 1.
// Latency : count_out registered; rollover_flag is decoded from count_out.
// Backpressure: none; count_enable freezes, clear (priority) forces zero.
// Ports   : clk, n_rst (async active-low), clear, count_enable,
//           rollover_val (wrap point), count_out, rollover_flag.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  localparam logic [NUM_CNT_BITS-1:0] W_ONE = NUM_CNT_BITS'(1);

  logic [NUM_CNT_BITS-1:0] r_count;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (count_enable) begin
      // Wrap at or past the limit so a lowered rollover_val never lets the
      // count run away through the full range.
      if (r_count >= rollover_val) r_count <= W_ONE;
      else                         r_count <= r_count + W_ONE;
    end
  end

  assign count_out     = r_count;
  assign rollover_flag = (r_count == rollover_val);

endmodule

// File: rtl/bit_timer.sv
// Purpose : receive bit timing; half-bit wait, then one strobe per bit, then done.
// Latency : all outputs registered; first strobe H+C cycles after start.
// Backpressure: none; start ignored while busy, abort returns to IDLE.
// Ports   : clk, n_rst, start, abort, clks_per_bit (C), bits_per_packet (B)
//           -> shift_strobe, packet_done, busy, bit_index.
module bit_timer
  import bit_timer_pkg::*;
#(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [NUM_CNT_BITS-1:0] clks_per_bit,
  input  logic [NUM_CNT_BITS-1:0] bits_per_packet,
  output logic                    shift_strobe,
  output logic                    packet_done,
  output logic                    busy,
  output logic [NUM_CNT_BITS-1:0] bit_index
);

  localparam logic [NUM_CNT_BITS-1:0] W_MIN_C = NUM_CNT_BITS'(MIN_CLKS_PER_BIT);
  localparam logic [NUM_CNT_BITS-1:0] W_MIN_B = NUM_CNT_BITS'(MIN_BITS_PER_PACKET);
  localparam logic [NUM_CNT_BITS-1:0] W_ONE   = NUM_CNT_BITS'(1);

  state_t                  r_state;
  state_t                  w_next_state;
  logic [NUM_CNT_BITS-1:0] r_c;
  logic [NUM_CNT_BITS-1:0] r_b;
  logic [NUM_CNT_BITS-1:0] w_h;
  logic                    w_accept;
  logic                    w_strobe_d;
  logic                    w_cnt_clear;
  logic                    w_cnt_en;
  logic [NUM_CNT_BITS-1:0] w_rollover_val;
  logic [NUM_CNT_BITS-1:0] w_count;
  logic                    w_rollover;
  logic                    r_shift_strobe;
  logic                    r_packet_done;
  logic                    r_busy;
  logic [NUM_CNT_BITS-1:0] r_bit_index;

  assign w_h = r_c >> 1;

  flex_counter #(
    .NUM_CNT_BITS (NUM_CNT_BITS)
  ) u_cycle_cnt (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (w_cnt_clear),
    .count_enable  (w_cnt_en),
    .rollover_val  (w_rollover_val),
    .count_out     (w_count),
    .rollover_flag (w_rollover)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_strobe_d   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = HALF;
          w_accept     = 1'b1;
        end
      end
      HALF: begin
        if (w_rollover) w_next_state = BITS;
      end
      BITS: begin
        // The strobe register is loaded one cycle ahead of the counter wrap,
        // so the strobe becomes visible in the cycle the count reaches C.
        if (w_count == (r_c - W_ONE)) w_strobe_d = 1'b1;
        if (w_rollover && (r_bit_index == r_b)) w_next_state = DONE;
      end
      DONE: begin
        w_next_state = IDLE;
      end
    endcase
    if (abort) begin
      w_next_state = IDLE;
      w_accept     = 1'b0;
      w_strobe_d   = 1'b0;
    end
  end

  // Counting starts on the accept edge so cycle n of HALF holds count n; the
  // HALF->BITS hand-off restarts the count at 1 through the counter's own wrap.
  assign w_cnt_en       = w_accept || (r_state == HALF) || (r_state == BITS);
  assign w_cnt_clear    = abort || (r_state == DONE) || ((r_state == IDLE) && !w_accept);
  assign w_rollover_val = (r_state == BITS) ? r_c : w_h;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_c <= '0;
      r_b <= '0;
    end else if (w_accept) begin
      r_c <= (clks_per_bit < W_MIN_C) ? W_MIN_C : clks_per_bit;
      r_b <= (bits_per_packet < W_MIN_B) ? W_MIN_B : bits_per_packet;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_shift_strobe <= 1'b0;
      r_packet_done  <= 1'b0;
      r_busy         <= 1'b0;
      r_bit_index    <= '0;
    end else begin
      r_shift_strobe <= w_strobe_d;
      r_packet_done  <= (w_next_state == DONE);
      r_busy         <= (w_next_state != IDLE);
      if (w_next_state == IDLE) r_bit_index <= '0;
      else if (w_strobe_d)      r_bit_index <= r_bit_index + W_ONE;
    end
  end

  assign shift_strobe = r_shift_strobe;
  assign packet_done  = r_packet_done;
  assign busy         = r_busy;
  assign bit_index    = r_bit_index;

endmodule

// File: tb/tb_bit_timer.sv
// Purpose : self-checking bench for bit_timer against an arithmetic timing model.
// Latency : model predicts each output per cycle from the start cycle offset.
// Backpressure: n/a.
module tb_bit_timer;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [N-1:0] clks_per_bit = '0;
  logic [N-1:0] bits_per_packet = '0;
  logic         shift_strobe;
  logic         packet_done;
  logic         busy;
  logic [N-1:0] bit_index;

  int n_total = 0;
  int n_bad   = 0;
  int t       = 0;

  // Reference packet: start cycle, clamped period, clamped length, half period.
  bit m_act = 1'b0;
  int m_s   = 0;
  int m_c   = 2;
  int m_b   = 1;
  int m_h   = 1;

  bit_timer #(.NUM_CNT_BITS(N)) dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .start           (start),
    .abort           (abort),
    .clks_per_bit    (clks_per_bit),
    .bits_per_packet (bits_per_packet),
    .shift_strobe    (shift_strobe),
    .packet_done     (packet_done),
    .busy            (busy),
    .bit_index       (bit_index)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d", tag, t, obs, exp);
    end
  endtask

  function automatic int last_cycle();
    return m_h + m_b * m_c + 1;
  endfunction

  function automatic bit model_busy(input int tc);
    int d;
    d = tc - m_s;
    return m_act && (d >= 1) && (d <= last_cycle());
  endfunction

  task automatic compare_cycle();
    int d, L;
    int e_busy, e_done, e_str, e_idx;
    e_busy = 0; e_done = 0; e_str = 0; e_idx = 0;
    d = t - m_s;
    L = last_cycle();
    if (model_busy(t)) begin
      e_busy = 1;
      e_done = (d == L) ? 1 : 0;
      if (d >= L)             e_idx = m_b;
      else if (d >= m_h + m_c) e_idx = (d - m_h) / m_c;
      if ((d >= m_h + m_c) && (d < L) && (((d - m_h) % m_c) == 0)) e_str = 1;
    end
    check("busy",   32'(busy),         32'(e_busy));
    check("done",   32'(packet_done),  32'(e_done));
    check("strobe", 32'(shift_strobe), 32'(e_str));
    check("index",  32'(bit_index),    32'(e_idx));
  endtask

  task automatic model_update(input bit st, input bit ab, input int c, input int b);
    bit was_idle;
    was_idle = !model_busy(t);
    if (ab) m_act = 1'b0;
    else if (m_act && (t - m_s >= last_cycle())) m_act = 1'b0;
    if (st && !ab && was_idle) begin
      m_act = 1'b1;
      m_s   = t;
      m_c   = (c < 2) ? 2 : c;
      m_b   = (b == 0) ? 1 : b;
      m_h   = m_c / 2;
    end
  endtask

  // One clock cycle: drive inputs just after the edge, check mid-cycle.
  task automatic step(input bit st, input bit ab, input int c, input int b);
    @(posedge clk);
    #1;
    t++;
    start           = st;
    abort           = ab;
    clks_per_bit    = N'(c);
    bits_per_packet = N'(b);
    @(negedge clk);
    compare_cycle();
    model_update(st, ab, c, b);
  endtask

  task automatic idle(input int n, input int c, input int b);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, c, b);
  endtask

  initial begin
    // Reset state.
    #12;
    check("rst_busy",   32'(busy),         32'd0);
    check("rst_done",   32'(packet_done),  32'd0);
    check("rst_strobe", 32'(shift_strobe), 32'd0);
    check("rst_index",  32'(bit_index),    32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    idle(3, 0, 0);

    // Nominal: C=10, B=9.
    step(1'b1, 1'b0, 10, 9);
    idle(100, 10, 9);

    // Odd period, then clamped minimum.
    step(1'b1, 1'b0, 7, 2);
    idle(22, 7, 2);
    step(1'b1, 1'b0, 1, 0);
    idle(8, 1, 0);

    // Config change and start while busy are ignored.
    step(1'b1, 1'b0, 4, 3);
    idle(5, 15, 15);
    step(1'b1, 1'b0, 15, 15);
    idle(14, 15, 15);

    // Abort in cycle 20, then abort with start while idle.
    step(1'b1, 1'b0, 8, 5);
    idle(19, 8, 5);
    step(1'b0, 1'b1, 8, 5);
    idle(30, 8, 5);
    step(1'b1, 1'b1, 5, 5);
    idle(10, 5, 5);

    // Back-to-back: C=5, B=3 ends busy at cycle 18; restart at cycle 19.
    step(1'b1, 1'b0, 5, 3);
    idle(18, 5, 3);
    step(1'b1, 1'b0, 5, 3);
    idle(22, 5, 3);

    // Reset asserted mid-BITS after three strobes.
    step(1'b1, 1'b0, 10, 9);
    idle(40, 10, 9);
    @(posedge clk);
    #3;
    n_rst = 1'b0;
    m_act = 1'b0;
    #1;
    check("mid_rst_busy",   32'(busy),         32'd0);
    check("mid_rst_done",   32'(packet_done),  32'd0);
    check("mid_rst_strobe", 32'(shift_strobe), 32'd0);
    check("mid_rst_index",  32'(bit_index),    32'd0);
    @(posedge clk);
    #2;
    n_rst = 1'b1;
    idle(20, 10, 9);

    // Randomized traffic: frequent starts, rare aborts, random config.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    end
    idle(300, 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
